// File: rtl/decode_ctrl_stage_if.sv
// ID/EX control bundle produced by decode_ctrl_stage and consumed by the execute datapath.
// master = decode stage (drives), slave = execute stage (observes).
interface decode_ctrl_stage_if;
    logic       Valid_E;
    logic       RegWrite_E;
    logic       MemWrite_E;
    logic       Branch_E;
    logic       ALUSrc_b_E;
    logic       CSRWrite_E;
    logic       Is_MRET_E;
    logic       Is_ECALL_E;
    logic       Illegal_Instr_E;
    logic       MulDiv_E;
    logic [1:0] Jump_E;
    logic [1:0] ResultSrc_E;
    logic [1:0] ALUSrc_a_E;
    logic [3:0] ALU_Control_E;
    logic [2:0] MulDiv_Op_E;

    modport master (
        output Valid_E, RegWrite_E, MemWrite_E, Branch_E, ALUSrc_b_E, CSRWrite_E, Is_MRET_E,
               Is_ECALL_E, Illegal_Instr_E, MulDiv_E, Jump_E, ResultSrc_E, ALUSrc_a_E,
               ALU_Control_E, MulDiv_Op_E
    );

    modport slave (
        input Valid_E, RegWrite_E, MemWrite_E, Branch_E, ALUSrc_b_E, CSRWrite_E, Is_MRET_E,
              Is_ECALL_E, Illegal_Instr_E, MulDiv_E, Jump_E, ResultSrc_E, ALUSrc_a_E,
              ALU_Control_E, MulDiv_Op_E
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// RV32 decode-control stage: decodes D, registers controls into ID/EX with stall/flush.
// Define RV32M_EN to decode MUL/DIV and sequence their multi-cycle E-stage occupancy.
module decode_ctrl_stage #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                Instr_In_D,
    input  logic                       Valid_D,
    input  logic                       Stall_E,
    input  logic                       Flush_E,
    output logic [2:0]                 ImmSrc_D,
    output logic                       Stall_D,
    decode_ctrl_stage_if.master        ctrl_e
);
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       alu_src_b;
        logic       csr_write;
        logic       is_mret;
        logic       is_ecall;
        logic       illegal;
        logic       mul_div;
        logic [1:0] jump;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [3:0] alu_control;
        logic [2:0] mul_div_op;
    } ctrl_t;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [6:0] F7Alt = 7'b0100000;
    localparam logic [6:0] F7Mul = 7'b0000001;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rd;
    logic [11:0] imm12;
    logic [2:0]  imm_src;
    logic        alt;
    ctrl_t       dec, ctrl_d, ctrl_q;

    assign opcode = Instr_In_D[6:0];
    assign rd     = Instr_In_D[11:7];
    assign funct3 = Instr_In_D[14:12];
    assign rs1    = Instr_In_D[19:15];
    assign funct7 = Instr_In_D[31:25];
    assign imm12  = Instr_In_D[31:20];

    always_comb begin
        dec       = '0;
        imm_src   = 3'b000;
        alt       = 1'b0;
        dec.valid = 1'b1;
        case (opcode)
            OpLui: begin
                dec.reg_write = 1'b1; dec.alu_src_b = 1'b1; dec.alu_src_a = 2'b10;
                imm_src = 3'b011;
            end
            OpAuipc: begin
                dec.reg_write = 1'b1; dec.alu_src_b = 1'b1; dec.alu_src_a = 2'b01;
                imm_src = 3'b011;
            end
            OpJal: begin
                dec.reg_write = 1'b1; dec.jump = 2'b01; dec.result_src = 2'b10;
                dec.alu_src_a = 2'b01; dec.alu_src_b = 1'b1; imm_src = 3'b100;
            end
            OpJalr: begin
                dec.reg_write = 1'b1; dec.jump = 2'b10; dec.result_src = 2'b10;
                dec.alu_src_b = 1'b1;
            end
            OpBranch: begin
                dec.branch = 1'b1; imm_src = 3'b010;
                case (funct3[2:1])
                    2'b10:   dec.alu_control = 4'b0101;
                    2'b11:   dec.alu_control = 4'b0110;
                    default: dec.alu_control = 4'b0001;
                endcase
            end
            OpLoad: begin
                dec.reg_write = 1'b1; dec.result_src = 2'b01; dec.alu_src_b = 1'b1;
            end
            OpStore: begin
                dec.mem_write = 1'b1; dec.alu_src_b = 1'b1; imm_src = 3'b001;
            end
            OpImm, OpReg: begin
                dec.reg_write = 1'b1;
                dec.alu_src_b = ~opcode[5];
                if (opcode[5]) begin
                    if (funct7 == F7Alt) begin
                        alt         = 1'b1;
                        dec.illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                    end else if (funct7 == F7Mul) begin
`ifdef RV32M_EN
                        dec.mul_div    = 1'b1;
                        dec.mul_div_op = funct3;
`else
                        dec.illegal    = 1'b1;
`endif
                    end else if (funct7 != 7'b0) begin
                        dec.illegal = 1'b1;
                    end
                end else if (funct3 == 3'b001) begin
                    dec.illegal = (funct7 != 7'b0);
                end else if (funct3 == 3'b101) begin
                    alt         = (funct7 == F7Alt);
                    dec.illegal = (funct7 != 7'b0) && !alt;
                end
                case (funct3)
                    3'b000:  dec.alu_control = alt ? 4'b0001 : 4'b0000;
                    3'b001:  dec.alu_control = 4'b0111;
                    3'b010:  dec.alu_control = 4'b0101;
                    3'b011:  dec.alu_control = 4'b0110;
                    3'b100:  dec.alu_control = 4'b0100;
                    3'b101:  dec.alu_control = alt ? 4'b1001 : 4'b1000;
                    3'b110:  dec.alu_control = 4'b0011;
                    default: dec.alu_control = 4'b0010;
                endcase
                if (dec.mul_div) dec.alu_control = 4'b0000;
            end
            OpFence: ;
            OpSystem: begin
                if (funct3 == 3'b000) begin
                    if (rs1 != 5'd0 || rd != 5'd0) dec.illegal = 1'b1;
                    else if (imm12 == 12'h000)      dec.is_ecall = 1'b1;
                    else if (imm12 == 12'h302)      dec.is_mret  = 1'b1;
                    else                            dec.illegal  = 1'b1;
                end else if (funct3 == 3'b100) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_write   = 1'b1;
                    dec.result_src  = 2'b11;
                    dec.alu_control = 4'b1111;
                    // set/clear with a zero rs1/uimm field is a pure read
                    dec.csr_write   = !(funct3[1] && rs1 == 5'd0);
                    if (funct3[2]) begin
                        dec.alu_src_b = 1'b1;
                        imm_src       = 3'b101;
                    end
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
        if (!Valid_D) dec = '0;
    end

    assign ImmSrc_D = imm_src;

`ifdef RV32M_EN
    typedef enum logic [0:0] {StIdle, StMdBusy} state_e;

    localparam logic [5:0] MulLast = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DivLast = 6'(DIV_CYCLES - 1);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (Flush_E) begin
            ctrl_d  = '0;
            state_d = StIdle;
            cnt_d   = 6'd0;
        end else if (state_q == StMdBusy) begin
            // counts down even while Stall_E holds the E register
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) state_d = StIdle;
        end else if (!Stall_E) begin
            ctrl_d = dec;
            if (dec.mul_div) begin
                cnt_d = dec.mul_div_op[2] ? DivLast : MulLast;
                if (cnt_d != 6'd0) state_d = StMdBusy;
            end
        end
    end

    assign Stall_D = (state_q == StMdBusy);
`else
    always_comb begin
        ctrl_d = ctrl_q;
        if (Flush_E)       ctrl_d = '0;
        else if (!Stall_E) ctrl_d = dec;
    end

    assign Stall_D = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) ctrl_q <= '0;
        else     ctrl_q <= ctrl_d;
    end

    assign ctrl_e.Valid_E         = ctrl_q.valid;
    assign ctrl_e.RegWrite_E      = ctrl_q.reg_write;
    assign ctrl_e.MemWrite_E      = ctrl_q.mem_write;
    assign ctrl_e.Branch_E        = ctrl_q.branch;
    assign ctrl_e.ALUSrc_b_E      = ctrl_q.alu_src_b;
    assign ctrl_e.CSRWrite_E      = ctrl_q.csr_write;
    assign ctrl_e.Is_MRET_E       = ctrl_q.is_mret;
    assign ctrl_e.Is_ECALL_E      = ctrl_q.is_ecall;
    assign ctrl_e.Illegal_Instr_E = ctrl_q.illegal;
    assign ctrl_e.MulDiv_E        = ctrl_q.mul_div;
    assign ctrl_e.Jump_E          = ctrl_q.jump;
    assign ctrl_e.ResultSrc_E     = ctrl_q.result_src;
    assign ctrl_e.ALUSrc_a_E      = ctrl_q.alu_src_a;
    assign ctrl_e.ALU_Control_E   = ctrl_q.alu_control;
    assign ctrl_e.MulDiv_Op_E     = ctrl_q.mul_div_op;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage; expected control bundles are hand-encoded constants.
// M-extension sequencing is exercised when RV32M_EN is defined, else its illegality is checked.
module tb_decode_ctrl_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        valid_d, stall_e, flush_e;
    logic [2:0]  imm_src_d;
    logic        stall_d;
    int          total = 0;
    int          bad   = 0;

    decode_ctrl_stage_if ctrl_if ();

    decode_ctrl_stage #(
        .MUL_CYCLES (2),
        .DIV_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Instr_In_D (instr),
        .Valid_D    (valid_d),
        .Stall_E    (stall_e),
        .Flush_E    (flush_e),
        .ImmSrc_D   (imm_src_d),
        .Stall_D    (stall_d),
        .ctrl_e     (ctrl_if)
    );

    always #5 clk = ~clk;

    // flag order: valid rw mw br alusrc_b csrw mret ecall illegal muldiv
    localparam logic [9:0] V  = 10'b1000000000;
    localparam logic [9:0] RW = 10'b0100000000;
    localparam logic [9:0] MW = 10'b0010000000;
    localparam logic [9:0] BR = 10'b0001000000;
    localparam logic [9:0] BS = 10'b0000100000;
    localparam logic [9:0] CW = 10'b0000010000;
    localparam logic [9:0] MR = 10'b0000001000;
    localparam logic [9:0] EC = 10'b0000000100;
    localparam logic [9:0] IL = 10'b0000000010;
    localparam logic [9:0] MD = 10'b0000000001;

    function automatic logic [31:0] mk(input logic [9:0] flags, input logic [1:0] jump,
                                       input logic [1:0] rsrc, input logic [1:0] asrc,
                                       input logic [3:0] alu, input logic [2:0] mdop);
        return {9'd0, flags, jump, rsrc, asrc, alu, mdop};
    endfunction

    function automatic logic [31:0] obs();
        return {9'd0, ctrl_if.Valid_E, ctrl_if.RegWrite_E, ctrl_if.MemWrite_E, ctrl_if.Branch_E,
                ctrl_if.ALUSrc_b_E, ctrl_if.CSRWrite_E, ctrl_if.Is_MRET_E, ctrl_if.Is_ECALL_E,
                ctrl_if.Illegal_Instr_E, ctrl_if.MulDiv_E, ctrl_if.Jump_E, ctrl_if.ResultSrc_E,
                ctrl_if.ALUSrc_a_E, ctrl_if.ALU_Control_E, ctrl_if.MulDiv_Op_E};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present instruction, check combinational ImmSrc, clock it in, check the E bundle
    task automatic load(input string tag, input logic [31:0] ins, input logic [2:0] imm,
                        input logic [31:0] exp);
        instr = ins;
        #1;
        check({tag, ".imm"}, {29'd0, imm_src_d}, {29'd0, imm});
        tick();
        check(tag, obs(), exp);
    endtask

    localparam logic [31:0] Add = 32'h002080B3;

    initial begin
        rst = 1'b1; instr = 32'h00000013; valid_d = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
        tick(); tick();
        check("reset.bundle", obs(), 32'd0);
        check("reset.stall_d", {31'd0, stall_d}, 32'd0);
        rst = 1'b0;
        tick();
        check("addi", obs(), mk(V | RW | BS, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));

        load("sub",      32'h403100B3, 3'b000, mk(V | RW, 2'd0, 2'd0, 2'd0, 4'h1, 3'd0));
        load("badf7",    32'h203100B3, 3'b000, mk(V | IL, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        load("csrrs_x0", 32'h300020F3, 3'b000, mk(V | RW, 2'd0, 2'd3, 2'd0, 4'hF, 3'd0));
        load("mret",     32'h30200073, 3'b000, mk(V | MR, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        load("ecall",    32'h00000073, 3'b000, mk(V | EC, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        load("ebreak",   32'h00100073, 3'b000, mk(V | IL, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        load("csrrw",    32'h300110F3, 3'b000, mk(V | RW | CW, 2'd0, 2'd3, 2'd0, 4'hF, 3'd0));
        load("csrrsi",   32'h3002E0F3, 3'b101,
             mk(V | RW | CW | BS, 2'd0, 2'd3, 2'd0, 4'hF, 3'd0));
        load("lw",       32'h00012083, 3'b000, mk(V | RW | BS, 2'd0, 2'd1, 2'd0, 4'h0, 3'd0));
        load("sw",       32'h00112023, 3'b001, mk(V | MW | BS, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        load("blt",      32'h0020C463, 3'b010, mk(V | BR, 2'd0, 2'd0, 2'd0, 4'h5, 3'd0));
        load("jal",      32'h010000EF, 3'b100, mk(V | RW | BS, 2'd1, 2'd2, 2'd1, 4'h0, 3'd0));
        load("jalr",     32'h000100E7, 3'b000, mk(V | RW | BS, 2'd2, 2'd2, 2'd0, 4'h0, 3'd0));
        load("lui",      32'h123450B7, 3'b011, mk(V | RW | BS, 2'd0, 2'd0, 2'd2, 4'h0, 3'd0));
        load("srai",     32'h40315093, 3'b000, mk(V | RW | BS, 2'd0, 2'd0, 2'd0, 4'h9, 3'd0));
        load("slli_bad", 32'h40311093, 3'b000, mk(V | IL, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        load("srli_bad", 32'h02315093, 3'b000, mk(V | IL, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        load("fence",    32'h0000000F, 3'b000, mk(V, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        load("unk_op",   32'h0000007F, 3'b000, mk(V | IL, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));

        valid_d = 1'b0;
        load("bubble", Add, 3'b000, 32'd0);
        valid_d = 1'b1;

        // Stall_E holds, Flush_E beats hold
        load("add", Add, 3'b000, mk(V | RW, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        stall_e = 1'b1;
        load("stall_hold", 32'h403100B3, 3'b000, mk(V | RW, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        flush_e = 1'b1;
        tick();
        check("flush_over_stall", obs(), 32'd0);
        flush_e = 1'b0; stall_e = 1'b0;

`ifdef RV32M_EN
        // DIV, N=4: Stall_D high 3 cycles, E held 4 cycles, add loads on 4th edge
        load("div", 32'h0220C0B3, 3'b000, mk(V | RW | MD, 2'd0, 2'd0, 2'd0, 4'h0, 3'd4));
        instr = Add;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("div.stall_d%0d", i), {31'd0, stall_d}, 32'd1);
            check($sformatf("div.op%0d", i), {29'd0, ctrl_if.MulDiv_Op_E}, 32'd4);
            tick();
        end
        check("div.stall_end", {31'd0, stall_d}, 32'd0);
        check("div.last", obs(), mk(V | RW | MD, 2'd0, 2'd0, 2'd0, 4'h0, 3'd4));
        tick();
        check("div.next_add", obs(), mk(V | RW, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));

        // flush during 2nd busy cycle
        load("div2", 32'h0220C0B3, 3'b000, mk(V | RW | MD, 2'd0, 2'd0, 2'd0, 4'h0, 3'd4));
        instr = Add;
        tick();
        check("div2.busy", {31'd0, stall_d}, 32'd1);
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        check("div2.flush", obs(), 32'd0);
        check("div2.stall_d", {31'd0, stall_d}, 32'd0);
        tick();
        check("div2.resume", obs(), mk(V | RW, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));

        // flush with a candidate M op in D: counter never starts
        flush_e = 1'b1;
        load("flush_mop", 32'h0220C0B3, 3'b000, 32'd0);
        check("flush_mop.stall_d", {31'd0, stall_d}, 32'd0);
        flush_e = 1'b0;
        instr = Add;
        tick();
        check("flush_mop.after", {31'd0, stall_d}, 32'd0);

        // MUL (N=2) with Stall_E held 5 cycles
        load("mul", 32'h022080B3, 3'b000, mk(V | RW | MD, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        check("mul.stall_d", {31'd0, stall_d}, 32'd1);
        instr = Add;
        stall_e = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("mul.hold%0d", i), {31'd0, ctrl_if.MulDiv_E}, 32'd1);
            check($sformatf("mul.sd%0d", i), {31'd0, stall_d}, 32'd0);
        end
        stall_e = 1'b0;
        tick();
        check("mul.next_add", obs(), mk(V | RW, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
`else
        load("div_off", 32'h0220C0B3, 3'b000, mk(V | IL, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        check("div_off.stall_d", {31'd0, stall_d}, 32'd0);
        load("mul_off", 32'h022080B3, 3'b000, mk(V | IL, 2'd0, 2'd0, 2'd0, 4'h0, 3'd0));
        tick();
        check("mul_off.stall_d", {31'd0, stall_d}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
